// File: rtl/axi4_lite_mem_slave.sv
// AXI4-Lite slave backed by a word-addressed memory.
// Write path: AW and W captured independently, committed one cycle after both
// are held, then a single B response. Read path: two-state FSM with one-cycle
// read latency. Both paths run concurrently; memory is not cleared by reset.
module axi4_lite_mem_slave #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DEPTH     = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                iCLK,
  input  logic                iRST,
  // write address
  input  logic                s_AWVALID,
  input  logic [2:0]          s_AWPROT,
  input  logic [ADDR_W-1:0]   s_AWADDR,
  output logic                s_AWREADY,
  // write data
  input  logic                s_WVALID,
  input  logic [DATA_W/8-1:0] s_WSTRB,
  input  logic [DATA_W-1:0]   s_WDATA,
  output logic                s_WREADY,
  // write response
  input  logic                s_BREADY,
  output logic                s_BVALID,
  output logic [1:0]          s_BRESP,
  // read address
  input  logic                s_ARVALID,
  input  logic [2:0]          s_ARPROT,
  input  logic [ADDR_W-1:0]   s_ARADDR,
  output logic                s_ARREADY,
  // read data
  input  logic                s_RREADY,
  output logic                s_RVALID,
  output logic [DATA_W-1:0]   s_RDATA,
  output logic [1:0]          s_RRESP
);

  localparam int unsigned STRB_W  = DATA_W / 8;
  localparam int unsigned BYTE_LG = $clog2(STRB_W);
  localparam int unsigned IDX_LG  = $clog2(DEPTH);
  localparam int unsigned SPAN_LG = BYTE_LG + IDX_LG;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_DECERR = 2'b11;

  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  // BASE_ADDR is aligned to the window size, so the window test reduces to
  // comparing the address bits above the window.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return (a >> SPAN_LG) == (BASE_ADDR >> SPAN_LG);
  endfunction

  function automatic logic [IDX_LG-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return IDX_LG'((a - BASE_ADDR) >> BYTE_LG);
  endfunction

  // Zero at time 0 via declaration; deliberately outside the reset domain.
  logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};

  // Readies are held low until the first edge after reset release.
  logic live_q;

  logic              aw_held_q, aw_held_d;
  logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
  logic              w_held_q,  w_held_d;
  logic [DATA_W-1:0] w_data_q,  w_data_d;
  logic [STRB_W-1:0] w_strb_q,  w_strb_d;
  logic              b_valid_q, b_valid_d;
  logic [1:0]        b_resp_q,  b_resp_d;

  r_state_e          r_state_q, r_state_d;
  logic [DATA_W-1:0] r_data_q,  r_data_d;
  logic [1:0]        r_resp_q,  r_resp_d;

  logic aw_fire, w_fire, ar_fire, commit, wr_ok, ar_ok;
  logic [IDX_LG-1:0] wr_idx, ar_idx;

  logic unused_prot;
  assign unused_prot = ^{s_AWPROT, s_ARPROT};

  assign s_AWREADY = live_q & ~aw_held_q & ~b_valid_q;
  assign s_WREADY  = live_q & ~w_held_q  & ~b_valid_q;
  assign s_BVALID  = b_valid_q;
  assign s_BRESP   = b_resp_q;
  assign s_ARREADY = live_q & (r_state_q == R_IDLE);
  assign s_RVALID  = (r_state_q == R_DATA);
  assign s_RDATA   = r_data_q;
  assign s_RRESP   = r_resp_q;

  assign aw_fire = s_AWVALID & s_AWREADY;
  assign w_fire  = s_WVALID  & s_WREADY;
  assign ar_fire = s_ARVALID & s_ARREADY;
  assign commit  = aw_held_q & w_held_q;
  assign wr_ok   = in_range(aw_addr_q);
  assign wr_idx  = word_idx(aw_addr_q);
  assign ar_ok   = in_range(s_ARADDR);
  assign ar_idx  = word_idx(s_ARADDR);

  // Write path next state: capture AW/W, commit when both held, retire B.
  always_comb begin
    aw_held_d = aw_held_q;
    aw_addr_d = aw_addr_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    b_valid_d = b_valid_q;
    b_resp_d  = b_resp_q;
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      b_valid_d = 1'b1;
      b_resp_d  = wr_ok ? RESP_OKAY : RESP_DECERR;
    end else begin
      if (aw_fire) begin
        aw_held_d = 1'b1;
        aw_addr_d = s_AWADDR;
      end
      if (w_fire) begin
        w_held_d = 1'b1;
        w_data_d = s_WDATA;
        w_strb_d = s_WSTRB;
      end
      if (b_valid_q && s_BREADY) b_valid_d = 1'b0;
    end
  end

  // Read FSM next state: latch data/resp on AR, hold until R handshake.
  always_comb begin
    r_state_d = r_state_q;
    r_data_d  = r_data_q;
    r_resp_d  = r_resp_q;
    case (r_state_q)
      R_IDLE: if (ar_fire) begin
        r_data_d  = ar_ok ? mem_q[ar_idx] : '0;
        r_resp_d  = ar_ok ? RESP_OKAY : RESP_DECERR;
        r_state_d = R_DATA;
      end
      R_DATA: if (s_RREADY) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Control and holding registers; reset aborts any transaction in flight.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      live_q    <= 1'b0;
      aw_held_q <= 1'b0;
      aw_addr_q <= '0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      b_valid_q <= 1'b0;
      b_resp_q  <= RESP_OKAY;
      r_state_q <= R_IDLE;
      r_data_q  <= '0;
      r_resp_q  <= RESP_OKAY;
    end else begin
      live_q    <= 1'b1;
      aw_held_q <= aw_held_d;
      aw_addr_q <= aw_addr_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      b_valid_q <= b_valid_d;
      b_resp_q  <= b_resp_d;
      r_state_q <= r_state_d;
      r_data_q  <= r_data_d;
      r_resp_q  <= r_resp_d;
    end
  end

  // Byte-lane memory update on commit; a same-edge read sees the old word.
  always_ff @(posedge iCLK) begin
    if (commit && wr_ok) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (w_strb_q[i]) mem_q[wr_idx][i*8 +: 8] <= w_data_q[i*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi4_lite_mem_slave.sv
// Directed bench: 32-bit instance at a non-zero base plus a 64-bit, 16-word instance.
module tb_axi4_lite_mem_slave;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 32-bit DUT
  logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [31:0] awaddr = '0, araddr = '0, wdata = '0, rdata;
  logic [3:0]  wstrb = '0;
  logic [1:0]  bresp, rresp;

  // 64-bit DUT
  logic        x_awvalid = 0, x_wvalid = 0, x_bready = 0, x_arvalid = 0, x_rready = 0;
  logic        x_awready, x_wready, x_bvalid, x_arready, x_rvalid;
  logic [31:0] x_awaddr = '0, x_araddr = '0;
  logic [63:0] x_wdata = '0, x_rdata;
  logic [7:0]  x_wstrb = '0;
  logic [1:0]  x_bresp, x_rresp;

  axi4_lite_mem_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .BASE_ADDR(BASE)) dut (
    .iCLK(clk), .iRST(rst_n),
    .s_AWVALID(awvalid), .s_AWPROT(3'b000), .s_AWADDR(awaddr), .s_AWREADY(awready),
    .s_WVALID(wvalid), .s_WSTRB(wstrb), .s_WDATA(wdata), .s_WREADY(wready),
    .s_BREADY(bready), .s_BVALID(bvalid), .s_BRESP(bresp),
    .s_ARVALID(arvalid), .s_ARPROT(3'b000), .s_ARADDR(araddr), .s_ARREADY(arready),
    .s_RREADY(rready), .s_RVALID(rvalid), .s_RDATA(rdata), .s_RRESP(rresp));

  axi4_lite_mem_slave #(.DATA_W(64), .ADDR_W(32), .DEPTH(16), .BASE_ADDR(32'h0)) dut_w (
    .iCLK(clk), .iRST(rst_n),
    .s_AWVALID(x_awvalid), .s_AWPROT(3'b000), .s_AWADDR(x_awaddr), .s_AWREADY(x_awready),
    .s_WVALID(x_wvalid), .s_WSTRB(x_wstrb), .s_WDATA(x_wdata), .s_WREADY(x_wready),
    .s_BREADY(x_bready), .s_BVALID(x_bvalid), .s_BRESP(x_bresp),
    .s_ARVALID(x_arvalid), .s_ARPROT(3'b000), .s_ARADDR(x_araddr), .s_ARREADY(x_arready),
    .s_RREADY(x_rready), .s_RVALID(x_rvalid), .s_RDATA(x_rdata), .s_RRESP(x_rresp));

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // Drive AW+W together, then collect B. All tasks start/end 1 time unit after a rising edge.
  task automatic wr32(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic [1:0] resp, output bit ok);
    int n; bit aw_acc, w_acc;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; n = 0; ok = 0; resp = 2'bxx;
    while ((awvalid || wvalid) && n < 20) begin
      aw_acc = awvalid && awready; w_acc = wvalid && wready;
      @(posedge clk); #1; n++;
      if (aw_acc) awvalid = 0;
      if (w_acc) wvalid = 0;
    end
    bready = 1;
    while (!ok && n < 40) begin
      if (bvalid) begin resp = bresp; ok = 1; end
      @(posedge clk); #1; n++;
    end
    bready = 0; awvalid = 0; wvalid = 0;
  endtask

  task automatic rd32(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp,
                      output bit ok);
    int n; bit acc;
    araddr = a; arvalid = 1; n = 0; ok = 0; d = 'x; resp = 2'bxx;
    while (arvalid && n < 20) begin
      acc = arready;
      @(posedge clk); #1; n++;
      if (acc) arvalid = 0;
    end
    rready = 1;
    while (!ok && n < 40) begin
      if (rvalid) begin d = rdata; resp = rresp; ok = 1; end
      @(posedge clk); #1; n++;
    end
    rready = 0; arvalid = 0;
  endtask

  task automatic wr64(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                      output logic [1:0] resp, output bit ok);
    int n; bit aw_acc, w_acc;
    x_awaddr = a; x_wdata = d; x_wstrb = s; x_awvalid = 1; x_wvalid = 1; n = 0; ok = 0; resp = 2'bxx;
    while ((x_awvalid || x_wvalid) && n < 20) begin
      aw_acc = x_awvalid && x_awready; w_acc = x_wvalid && x_wready;
      @(posedge clk); #1; n++;
      if (aw_acc) x_awvalid = 0;
      if (w_acc) x_wvalid = 0;
    end
    x_bready = 1;
    while (!ok && n < 40) begin
      if (x_bvalid) begin resp = x_bresp; ok = 1; end
      @(posedge clk); #1; n++;
    end
    x_bready = 0; x_awvalid = 0; x_wvalid = 0;
  endtask

  task automatic rd64(input logic [31:0] a, output logic [63:0] d, output logic [1:0] resp,
                      output bit ok);
    int n; bit acc;
    x_araddr = a; x_arvalid = 1; n = 0; ok = 0; d = 'x; resp = 2'bxx;
    while (x_arvalid && n < 20) begin
      acc = x_arready;
      @(posedge clk); #1; n++;
      if (acc) x_arvalid = 0;
    end
    x_rready = 1;
    while (!ok && n < 40) begin
      if (x_rvalid) begin d = x_rdata; resp = x_rresp; ok = 1; end
      @(posedge clk); #1; n++;
    end
    x_rready = 0; x_arvalid = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({awready, wready, bvalid, arready, rvalid} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 00000", {awready, wready, bvalid, arready, rvalid});
    end
    checks++;
    if ({bresp, rresp, rdata} !== 36'h0) begin
      errors++; $display("FAIL reset_data got %h/%h/%h exp 0/0/0", bresp, rresp, rdata);
    end
    rst_n = 1;
    #1;
    checks++;
    if ({awready, wready, arready} !== 3'b000) begin
      errors++; $display("FAIL ready_before_edge got %b exp 000", {awready, wready, arready});
    end
    @(posedge clk); #1;
    checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      errors++; $display("FAIL ready_after_release got %b exp 111", {awready, wready, arready});
    end
  endtask

  task automatic test_basic();
    logic [1:0] r; logic [31:0] d; bit ok;
    wr32(BASE + 32'h10, 32'hDEADBEEF, 4'hF, r, ok);
    checks++;
    if (!ok || r !== 2'b00) begin errors++; $display("FAIL basic_bresp got %b ok %0d exp 00", r, ok); end
    rd32(BASE + 32'h10, d, r, ok);
    checks++;
    if (!ok || d !== 32'hDEADBEEF || r !== 2'b00) begin
      errors++; $display("FAIL basic_read got %h/%b exp deadbeef/00", d, r);
    end
    rd32(BASE + 32'h14, d, r, ok);
    checks++;
    if (!ok || d !== 32'h0 || r !== 2'b00) begin
      errors++; $display("FAIL init_zero got %h/%b exp 00000000/00", d, r);
    end
  endtask

  task automatic test_w_before_aw();
    logic [1:0] r; logic [31:0] d; bit ok;
    wr32(BASE + 32'h20, 32'hAABBCCDD, 4'hF, r, ok);
    wdata = 32'h11223344; wstrb = 4'b0101; wvalid = 1;
    @(posedge clk); #1;
    wvalid = 0;
    checks++;
    if (wready !== 1'b0) begin errors++; $display("FAIL w_held_wready got %b exp 0", wready); end
    @(posedge clk); #1;
    awaddr = BASE + 32'h20; awvalid = 1;
    checks++;
    if (awready !== 1'b1 || bvalid !== 1'b0) begin
      errors++; $display("FAIL aw_ready_w_held got %b/%b exp 1/0", awready, bvalid);
    end
    @(posedge clk); #1;
    awvalid = 0;
    checks++;
    if (bvalid !== 1'b0) begin errors++; $display("FAIL bvalid_early got %b exp 0", bvalid); end
    @(posedge clk); #1;
    checks++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      errors++; $display("FAIL bvalid_latency got %b/%b exp 1/00", bvalid, bresp);
    end
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
    checks++;
    if (bvalid !== 1'b0) begin errors++; $display("FAIL bvalid_drop got %b exp 0", bvalid); end
    rd32(BASE + 32'h20, d, r, ok);
    checks++;
    if (!ok || d !== 32'hAA22CC44 || r !== 2'b00) begin
      errors++; $display("FAIL strb_merge got %h/%b exp aa22cc44/00", d, r);
    end
  endtask

  task automatic test_strb_zero();
    logic [1:0] r; logic [31:0] d; bit ok;
    wr32(BASE + 32'h10, 32'hFFFFFFFF, 4'h0, r, ok);
    checks++;
    if (!ok || r !== 2'b00) begin errors++; $display("FAIL strb0_bresp got %b exp 00", r); end
    rd32(BASE + 32'h10, d, r, ok);
    checks++;
    if (!ok || d !== 32'hDEADBEEF) begin errors++; $display("FAIL strb0_data got %h exp deadbeef", d); end
  endtask

  task automatic test_decerr();
    logic [1:0] r; logic [31:0] d; bit ok;
    wr32(BASE + 32'h400, 32'h55AA55AA, 4'hF, r, ok);
    checks++;
    if (!ok || r !== 2'b11) begin errors++; $display("FAIL oor_bresp got %b exp 11", r); end
    rd32(BASE + 32'h400, d, r, ok);
    checks++;
    if (!ok || d !== 32'h0 || r !== 2'b11) begin
      errors++; $display("FAIL oor_read got %h/%b exp 00000000/11", d, r);
    end
    rd32(BASE, d, r, ok);
    checks++;
    if (!ok || d !== 32'h0 || r !== 2'b00) begin
      errors++; $display("FAIL oor_no_alias got %h/%b exp 00000000/00", d, r);
    end
    rd32(BASE - 32'h4, d, r, ok);
    checks++;
    if (!ok || r !== 2'b11) begin errors++; $display("FAIL below_base got %b exp 11", r); end
    wr32(BASE + 32'h3FC, 32'h76543210, 4'hF, r, ok);
    rd32(BASE + 32'h3FC, d, r, ok);
    checks++;
    if (!ok || d !== 32'h76543210 || r !== 2'b00) begin
      errors++; $display("FAIL last_word got %h/%b exp 76543210/00", d, r);
    end
  endtask

  task automatic test_stall();
    awaddr = BASE + 32'h40; wdata = 32'hCAFEF00D; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({bvalid, bresp, awready, wready} !== 5'b1_00_00) begin
        errors++; $display("FAIL b_stall cyc %0d got %b exp 10000", i, {bvalid, bresp, awready, wready});
      end
      @(posedge clk); #1;
    end
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
    checks++;
    if ({bvalid, awready, wready} !== 3'b011) begin
      errors++; $display("FAIL b_release got %b exp 011", {bvalid, awready, wready});
    end
    araddr = BASE + 32'h40; arvalid = 1;
    @(posedge clk); #1;
    arvalid = 0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({rvalid, arready} !== 2'b10 || rdata !== 32'hCAFEF00D || rresp !== 2'b00) begin
        errors++; $display("FAIL r_stall cyc %0d got %b/%h/%b exp 10/cafef00d/00", i, {rvalid, arready}, rdata, rresp);
      end
      @(posedge clk); #1;
    end
    rready = 1;
    @(posedge clk); #1;
    rready = 0;
    checks++;
    if ({rvalid, arready} !== 2'b01) begin
      errors++; $display("FAIL r_release got %b exp 01", {rvalid, arready});
    end
  endtask

  task automatic test_read_during_write();
    logic [1:0] r; logic [31:0] d; bit ok;
    awaddr = BASE + 32'h40; wdata = 32'h0BADF00D; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    araddr = BASE + 32'h40; arvalid = 1;
    @(posedge clk); #1;
    arvalid = 0;
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'hCAFEF00D || bvalid !== 1'b1) begin
      errors++; $display("FAIL rw_same_edge got %b/%h/%b exp 1/cafef00d/1", rvalid, rdata, bvalid);
    end
    bready = 1; rready = 1;
    @(posedge clk); #1;
    bready = 0; rready = 0;
    rd32(BASE + 32'h40, d, r, ok);
    checks++;
    if (!ok || d !== 32'h0BADF00D) begin errors++; $display("FAIL rw_after got %h exp 0badf00d", d); end
  endtask

  task automatic test_reset_abort();
    logic [1:0] r; logic [31:0] d; bit ok;
    wr32(BASE + 32'h30, 32'h12345678, 4'hF, r, ok);
    rd32(BASE + 32'h30, d, r, ok);
    awaddr = BASE + 32'h30; awvalid = 1;
    @(posedge clk); #1;
    awvalid = 0;
    checks++;
    if (awready !== 1'b0) begin errors++; $display("FAIL abort_aw_held got %b exp 0", awready); end
    wdata = 32'hFFFFFFFF;
    rst_n = 0;
    #1;
    checks++;
    if ({awready, wready, bvalid, arready, rvalid} !== 5'b0 || {bresp, rresp, rdata} !== 36'h0) begin
      errors++; $display("FAIL abort_outputs got %b/%h exp 00000/0", {awready, wready, bvalid, arready, rvalid}, {bresp, rresp, rdata});
    end
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    checks++;
    if ({awready, wready, bvalid} !== 3'b110) begin
      errors++; $display("FAIL abort_release got %b exp 110", {awready, wready, bvalid});
    end
    rd32(BASE + 32'h30, d, r, ok);
    checks++;
    if (!ok || d !== 32'h12345678) begin errors++; $display("FAIL abort_old_data got %h exp 12345678", d); end
  endtask

  task automatic test_wide();
    logic [1:0] r; logic [63:0] d; bit ok;
    wr64(32'h08, 64'h0123456789ABCDEF, 8'hFF, r, ok);
    checks++;
    if (!ok || r !== 2'b00) begin errors++; $display("FAIL wide_bresp got %b exp 00", r); end
    rd64(32'h08, d, r, ok);
    checks++;
    if (!ok || d !== 64'h0123456789ABCDEF || r !== 2'b00) begin
      errors++; $display("FAIL wide_read got %h/%b exp 0123456789abcdef/00", d, r);
    end
    rd64(32'h0C, d, r, ok);
    checks++;
    if (!ok || d !== 64'h0123456789ABCDEF) begin errors++; $display("FAIL wide_alias got %h exp 0123456789abcdef", d); end
    wr64(32'h80, 64'hFFFF, 8'hFF, r, ok);
    checks++;
    if (!ok || r !== 2'b11) begin errors++; $display("FAIL wide_oor got %b exp 11", r); end
    rd64(32'h00, d, r, ok);
    checks++;
    if (!ok || d !== 64'h0) begin errors++; $display("FAIL wide_word0 got %h exp 0", d); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_w_before_aw();
    test_strb_zero();
    test_decerr();
    test_stall();
    test_read_during_write();
    test_wide();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi4_lite_mem_slave.md
AXI4_LITE_MEM_SLAVE -- requirements
Module: axi4_lite_mem_slave

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data bus width in bits; legal values are 32 and 64.
REQ-002 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-003 SHALL have parameter DEPTH, default 256, number of DATA_W-bit words; must be a power of two, at least 2.
REQ-004 SHALL have parameter BASE_ADDR, default 0, byte address of word 0; must be aligned to DEPTH*DATA_W/8.
REQ-005 SHALL have port iCLK  in  1  clock; all state changes on the rising edge.
REQ-006 SHALL have port iRST  in  1  reset; asynchronous, active-low.
REQ-007 SHALL have write-address ports s_AWVALID in 1, s_AWPROT in 3 (ignored), s_AWADDR in ADDR_W, and s_AWREADY out 1.
REQ-008 SHALL have write-data ports s_WVALID in 1, s_WSTRB in DATA_W/8, s_WDATA in DATA_W, and s_WREADY out 1.
REQ-009 SHALL have write-response ports s_BREADY in 1, s_BVALID out 1, and s_BRESP out 2.
REQ-010 SHALL have read-address ports s_ARVALID in 1, s_ARPROT in 3 (ignored), s_ARADDR in ADDR_W, and s_ARREADY out 1.
REQ-011 SHALL have read-data ports s_RREADY in 1, s_RVALID out 1, s_RDATA out DATA_W, and s_RRESP out 2.

Function
REQ-012 Word index SHALL be (addr - BASE_ADDR) >> log2(DATA_W/8); the low address bits SHALL be ignored.
REQ-013 An address SHALL be in range iff BASE_ADDR <= addr < BASE_ADDR + DEPTH*DATA_W/8; otherwise the response SHALL be DECERR (2'b11). In-range responses SHALL be OKAY (2'b00).
REQ-014 Write channel SHALL capture AW and W independently into holding registers, in either order or in the same cycle.
REQ-015 s_AWREADY SHALL be high exactly when no AW is held and no B response is pending; the same rule SHALL apply to s_WREADY for W.
REQ-016 A beat SHALL be accepted on a cycle where VALID and READY are both high; payload is registered on that edge.
REQ-017 In the cycle after both AW and W are held, the block SHALL update in-range memory byte lane i only where WSTRB[i]=1.
REQ-018 In that same cycle it SHALL raise s_BVALID with the corresponding s_BRESP and clear both holding registers.
REQ-019 An out-of-range write SHALL leave memory unchanged.
REQ-020 s_BVALID and s_BRESP SHALL hold stable until s_BREADY is high; s_BVALID SHALL drop on the edge where s_BVALID and s_BREADY are both high.
REQ-021 Minimum write latency SHALL be 2 cycles: AW and W accepted at edge N, s_BVALID high after edge N+1. Throughput SHALL be one write per 3 cycles when s_BREADY is held high.
REQ-022 Read path SHALL use FSM R_IDLE -> R_DATA; s_ARREADY SHALL be high only in R_IDLE.
REQ-023 On AR acceptance in R_IDLE the block SHALL register s_RDATA (mem[idx], or 0 when out of range) and s_RRESP, set s_RVALID, and enter R_DATA: 1-cycle latency.
REQ-024 In R_DATA, s_RVALID, s_RDATA and s_RRESP SHALL hold stable until s_RREADY; on the handshake edge the block SHALL return to R_IDLE with s_RVALID low.
REQ-025 Read and write paths SHALL be fully concurrent.
REQ-026 A read accepted on the same edge as a memory update to the same word SHALL return the pre-write data.
REQ-027 WSTRB=0 SHALL complete normally with OKAY and no memory change.
REQ-028 Memory contents SHALL initialise to zero at time 0; they SHALL NOT be cleared by reset.

Reset
REQ-029 While iRST=0, s_AWREADY, s_WREADY, s_BVALID, s_ARREADY and s_RVALID SHALL be 0, s_BRESP and s_RRESP SHALL be 2'b00, s_RDATA SHALL be 0, holding registers SHALL be empty, and the FSM SHALL be in R_IDLE.
REQ-030 Reset asserted mid-transaction SHALL abort it with no memory write and no pending response.
REQ-031 The first edge after deassertion SHALL present s_AWREADY=s_WREADY=s_ARREADY=1.

Verification
REQ-032 Write 0xDEADBEEF to BASE_ADDR+0x10 with WSTRB=4'hF, then read it back -> BRESP=00, RDATA=0xDEADBEEF, RRESP=00.
REQ-033 Send W two cycles before AW, addr 0x20, data 0x11223344, WSTRB=4'b0101, over a word initially 0xAABBCCDD -> read returns 0xAA22CC44; BVALID exactly 2 cycles after AW acceptance.
REQ-034 Write and read at BASE_ADDR+DEPTH*4 (DATA_W=32) -> BRESP=11, RRESP=11, RDATA=0, memory unchanged.
REQ-035 Hold BREADY/RREADY low 5 cycles -> BVALID/RVALID, data and resp stable throughout; s_AWREADY, s_WREADY and s_ARREADY low until the handshake.
REQ-036 DATA_W=64, DEPTH=16: write 0x0123456789ABCDEF at 0x08 and read it back -> identical data; address 0x0C aliases word 1.
REQ-037 Assert iRST after AW accepted but before W -> all outputs at reset values; a subsequent read of that address returns its old data.
